// File: rtl/key_repeat_ctrl_pkg.sv
// Shared codes and default timing for the keyboard auto-repeat controller.
// Direction codes, DAS state encoding and default DAS timing live here.
package key_repeat_ctrl_pkg;

  localparam logic [1:0] DIR_NONE  = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    DAS_IDLE     = 2'd0,
    DAS_DELAY_ST = 2'd1,
    DAS_REPEAT   = 2'd2
  } das_state_t;

  // 100 ms first-repeat delay and 30 ms repeat period at 100 MHz.
  localparam int unsigned DEF_DAS_DELAY  = 10_000_000;
  localparam int unsigned DEF_DAS_PERIOD = 3_000_000;
  localparam int unsigned DEF_CNT_W      = 24;

endpackage

// File: rtl/rise_pulse.sv
// One-cycle registered pulse on the rising edge of a level input.
// The arm flag clears on reset, so a level held through reset never pulses.
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
      q     <= 1'b0;
    end else begin
      armed <= ~d;
      q     <= d & armed;
    end
  end

endmodule

// File: rtl/key_repeat_ctrl.sv
// Converts held key levels into single-cycle game command pulses with DAS on
// movement keys. Define SOFT_DROP_REPEAT_EN to give the down key auto-repeat.
module key_repeat_ctrl
  import key_repeat_ctrl_pkg::*;
#(
  parameter int unsigned DAS_DELAY  = DEF_DAS_DELAY,
  parameter int unsigned DAS_PERIOD = DEF_DAS_PERIOD,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       right,
  input  logic       left,
  input  logic       up,
  input  logic       down,
  input  logic       space,
  input  logic       shift,
  output logic       mv_left,
  output logic       mv_right,
  output logic       soft_drop,
  output logic       rotate,
  output logic       hard_drop,
  output logic       hold,
  output logic [1:0] active_dir
);

  localparam logic [CNT_W-1:0] LOAD_DELAY  = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] LOAD_PERIOD = CNT_W'(DAS_PERIOD - 1);

  das_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       dir_nxt;
  logic [1:0]       sel_dir;
  logic             sel_rise;
  logic             cnt_zero;
  logic [1:0]       fire_dir;
  logic             armed_left, armed_right;

  // Action keys: plain one-shot edge detectors.
  rise_pulse u_rot  (.clk(clk), .rst(rst), .d(up),    .q(rotate));
  rise_pulse u_hd   (.clk(clk), .rst(rst), .d(space), .q(hard_drop));
  rise_pulse u_hold (.clk(clk), .rst(rst), .d(shift), .q(hold));

`ifdef SOFT_DROP_REPEAT_EN
  logic armed_down;

  always_ff @(posedge clk) begin
    if (rst) armed_down <= 1'b0;
    else     armed_down <= ~down;
  end

  always_comb begin
    sel_dir = DIR_NONE;
    if (left)       sel_dir = DIR_LEFT;
    else if (right) sel_dir = DIR_RIGHT;
    else if (down)  sel_dir = DIR_DOWN;
  end

  always_comb begin
    sel_rise = 1'b0;
    case (sel_dir)
      DIR_LEFT:  sel_rise = armed_left;
      DIR_RIGHT: sel_rise = armed_right;
      DIR_DOWN:  sel_rise = armed_down;
      default:   sel_rise = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) soft_drop <= 1'b0;
    else     soft_drop <= (fire_dir == DIR_DOWN);
  end
`else
  rise_pulse u_sd (.clk(clk), .rst(rst), .d(down), .q(soft_drop));

  always_comb begin
    sel_dir = DIR_NONE;
    if (left)       sel_dir = DIR_LEFT;
    else if (right) sel_dir = DIR_RIGHT;
  end

  always_comb begin
    sel_rise = 1'b0;
    case (sel_dir)
      DIR_LEFT:  sel_rise = armed_left;
      DIR_RIGHT: sel_rise = armed_right;
      default:   sel_rise = 1'b0;
    endcase
  end
`endif

  // Arm flags mean "key was low last cycle"; cleared by reset to block held keys.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_left  <= 1'b0;
      armed_right <= 1'b0;
    end else begin
      armed_left  <= ~left;
      armed_right <= ~right;
    end
  end

  assign cnt_zero = (cnt == '0);

  // State register; active_dir holds the latched direction (NONE in IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DAS_IDLE;
      cnt        <= '0;
      active_dir <= DIR_NONE;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      active_dir <= dir_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = active_dir;
    case (state)
      DAS_IDLE: begin
        if (sel_rise) begin
          state_nxt = DAS_DELAY_ST;
          dir_nxt   = sel_dir;
          cnt_nxt   = LOAD_DELAY;
        end
      end
      DAS_DELAY_ST, DAS_REPEAT: begin
        if (sel_dir == DIR_NONE) begin
          state_nxt = DAS_IDLE;
          dir_nxt   = DIR_NONE;
          cnt_nxt   = '0;
        end else if (sel_dir != active_dir) begin
          state_nxt = DAS_DELAY_ST;
          dir_nxt   = sel_dir;
          cnt_nxt   = LOAD_DELAY;
        end else if (cnt_zero) begin
          state_nxt = DAS_REPEAT;
          cnt_nxt   = LOAD_PERIOD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DAS_IDLE;
        dir_nxt   = DIR_NONE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: which direction (if any) pulses on the next cycle.
  always_comb begin
    fire_dir = DIR_NONE;
    case (state)
      DAS_IDLE: begin
        if (sel_rise) fire_dir = sel_dir;
      end
      DAS_DELAY_ST, DAS_REPEAT: begin
        if (sel_dir != DIR_NONE) begin
          if (sel_dir != active_dir) fire_dir = sel_dir;
          else if (cnt_zero)         fire_dir = active_dir;
        end
      end
      default: fire_dir = DIR_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mv_left  <= 1'b0;
      mv_right <= 1'b0;
    end else begin
      mv_left  <= (fire_dir == DIR_LEFT);
      mv_right <= (fire_dir == DIR_RIGHT);
    end
  end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Scoreboard bench for key_repeat_ctrl with DAS_DELAY=10, DAS_PERIOD=4.
// Expected pulse/direction events are queued by stimulus and checked by a monitor.
module tb_key_repeat_ctrl;

  localparam int unsigned TD = 10;
  localparam int unsigned TP = 4;
  localparam int unsigned TW = 8;

  localparam logic [5:0] M_L    = 6'b000001;
  localparam logic [5:0] M_R    = 6'b000010;
  localparam logic [5:0] M_SD   = 6'b000100;
  localparam logic [5:0] M_ROT  = 6'b001000;
  localparam logic [5:0] M_HD   = 6'b010000;
  localparam logic [5:0] M_HOLD = 6'b100000;

  typedef struct {
    int         cyc;
    logic [5:0] m;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [1:0] d;
  } dir_ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic right = 1'b0, left = 1'b0, up = 1'b0, down = 1'b0, space = 1'b0, shift = 1'b0;
  logic mv_left, mv_right, soft_drop, rotate, hard_drop, hold;
  logic [1:0] active_dir;
  logic [5:0] pulses;

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  ev_t     exp_q[$];
  dir_ev_t dir_q[$];
  int      zero_q[$];
  ev_t     ev_cur;
  dir_ev_t dir_cur;

  key_repeat_ctrl #(
    .DAS_DELAY (TD),
    .DAS_PERIOD(TP),
    .CNT_W     (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .right     (right),
    .left      (left),
    .up        (up),
    .down      (down),
    .space     (space),
    .shift     (shift),
    .mv_left   (mv_left),
    .mv_right  (mv_right),
    .soft_drop (soft_drop),
    .rotate    (rotate),
    .hard_drop (hard_drop),
    .hold      (hold),
    .active_dir(active_dir)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign pulses = {hold, hard_drop, rotate, soft_drop, mv_right, mv_left};

  // Monitor: pops expectations whenever the DUT shows a pulse or a check is due.
  always @(negedge clk) begin
    if (pulses != 6'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected cyc=%0d got=%b required=none", cyc, pulses);
      end else begin
        ev_cur = exp_q.pop_front();
        if (ev_cur.cyc != cyc || ev_cur.m != pulses) begin
          fails++;
          $display("FAIL pulse cyc=%0d got=%b required cyc=%0d mask=%b",
                   cyc, pulses, ev_cur.cyc, ev_cur.m);
        end
      end
    end
    if (dir_q.size() != 0 && dir_q[0].cyc == cyc) begin
      dir_cur = dir_q.pop_front();
      checks++;
      if (active_dir !== dir_cur.d) begin
        fails++;
        $display("FAIL active_dir cyc=%0d got=%0d required=%0d", cyc, active_dir, dir_cur.d);
      end
    end
    if (zero_q.size() != 0 && zero_q[0] == cyc) begin
      void'(zero_q.pop_front());
      checks++;
      if ({pulses, active_dir} !== 8'b0) begin
        fails++;
        $display("FAIL outputs_zero cyc=%0d got=%b required=0", cyc, {pulses, active_dir});
      end
    end
    if (end_req && !end_ack) begin
      checks++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL pulses_missing got=%0d pending required=0 (next cyc=%0d)",
                 exp_q.size(), exp_q[0].cyc);
      end
      checks++;
      if (dir_q.size() + zero_q.size() != 0) begin
        fails++;
        $display("FAIL checks_missing got=%0d pending required=0", dir_q.size() + zero_q.size());
      end
      end_ack = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(output int b);
    @(posedge clk);
    #1;
    b = cyc;
  endtask

  task automatic push_ev(input int c, input logic [5:0] m);
    exp_q.push_back('{c, m});
  endtask

  task automatic push_dir(input int c, input logic [1:0] d);
    dir_q.push_back('{c, d});
  endtask

  initial begin
    int b;
    repeat (2) @(posedge clk);
    #1;
    zero_q.push_back(cyc);
    step();
    rst = 1'b0;
    repeat (3) step();

    // Hold left 30 cycles: immediate pulse, delay 10, then every 4.
    start(b);
    push_ev(b + 1, M_L);  push_ev(b + 11, M_L); push_ev(b + 15, M_L);
    push_ev(b + 19, M_L); push_ev(b + 23, M_L); push_ev(b + 27, M_L);
    push_dir(b + 1, 2'd1); push_dir(b + 30, 2'd1); push_dir(b + 31, 2'd0);
    for (int k = 0; k < 40; k++) begin
      left = (k < 30);
      step();
    end

    // Right tap with a shift tap: one mv_right and one hold together.
    start(b);
    push_ev(b + 1, M_R | M_HOLD);
    push_dir(b, 2'd0); push_dir(b + 1, 2'd2); push_dir(b + 3, 2'd2); push_dir(b + 4, 2'd0);
    for (int k = 0; k < 10; k++) begin
      right = (k < 3);
      shift = (k < 2);
      step();
    end

    // Left then right without a gap: fresh DAS on right.
    start(b);
    push_ev(b + 1, M_L); push_ev(b + 11, M_L);
    push_ev(b + 13, M_R); push_ev(b + 23, M_R);
    push_dir(b + 12, 2'd1); push_dir(b + 13, 2'd2); push_dir(b + 26, 2'd0);
    for (int k = 0; k < 35; k++) begin
      left  = (k < 12);
      right = (k >= 12 && k < 25);
      step();
    end

    // Up held with left; space taps, second one lands on a left repeat.
    start(b);
    push_ev(b + 1, M_L | M_ROT);
    push_ev(b + 6, M_HD);
    push_ev(b + 11, M_L);
    push_ev(b + 15, M_L | M_HD);
    for (int c = 19; c <= 47; c += 4) push_ev(b + c, M_L);
    for (int k = 0; k < 60; k++) begin
      left  = (k < 49);
      up    = (k < 50);
      space = (k >= 5 && k <= 6) || (k >= 14 && k <= 16);
      step();
    end

    // Reset mid-REPEAT with left held: silent until released and re-pressed.
    start(b);
    push_ev(b + 1, M_L); push_ev(b + 11, M_L); push_ev(b + 15, M_L); push_ev(b + 44, M_L);
    push_dir(b + 16, 2'd1); push_dir(b + 17, 2'd0); push_dir(b + 30, 2'd0);
    push_dir(b + 44, 2'd1); push_dir(b + 47, 2'd0);
    zero_q.push_back(b + 17);
    for (int k = 0; k < 55; k++) begin
      left = (k < 40) || (k >= 43 && k < 46);
      rst  = (k == 16);
      step();
    end

    // Down held 20 cycles.
    start(b);
`ifdef SOFT_DROP_REPEAT_EN
    push_ev(b + 1, M_SD); push_ev(b + 11, M_SD); push_ev(b + 15, M_SD); push_ev(b + 19, M_SD);
    push_dir(b + 1, 2'd3); push_dir(b + 21, 2'd0);
`else
    push_ev(b + 1, M_SD);
    push_dir(b + 1, 2'd0); push_dir(b + 15, 2'd0);
`endif
    for (int k = 0; k < 30; k++) begin
      down = (k < 20);
      step();
    end

    // Left and right pressed together: left wins, right takes over on left release.
    start(b);
    push_ev(b + 1, M_L); push_ev(b + 4, M_R);
    push_dir(b + 1, 2'd1); push_dir(b + 4, 2'd2); push_dir(b + 7, 2'd0);
    for (int k = 0; k < 12; k++) begin
      left  = (k < 3);
      right = (k < 6);
      step();
    end

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) step();
    if (!end_ack) begin
      fails++;
      $display("FAIL end_handshake got=0 required=1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
